// File: rtl/data_mem_ctrl_if.sv
// Load/store port between the RV32I core and the data-memory controller.
// The core drives the request side; the controller answers with data, LEDs, stall and error.
interface data_mem_ctrl_if #(
  parameter int unsigned MMIO_W = 8
);
  logic [31:0]       addr_i;
  logic [31:0]       w_data_i;
  logic              w_ena_i;
  logic              r_ena_i;
  logic [2:0]        sign_mask_i;
  logic [31:0]       r_data_o;
  logic [MMIO_W-1:0] led_o;
  logic              clk_stall_o;
  logic              err_o;

  modport master (
    output addr_i, w_data_i, w_ena_i, r_ena_i, sign_mask_i,
    input  r_data_o, led_o, clk_stall_o, err_o
  );

  modport slave (
    input  addr_i, w_data_i, w_ena_i, r_ena_i, sign_mask_i,
    output r_data_o, led_o, clk_stall_o, err_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: read-modify-write sub-word stores, sign/zero-extended
// loads, one LED MMIO register, and alignment/range checking with a one-cycle error pulse.
module data_mem_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] MMIO_ADDR = 32'h0000_2000,
  parameter int unsigned MMIO_W    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_WRITE,
    S_MMIO,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t state_q, state_d;

  // Request decode, evaluated on the IDLE capture edge
  logic          req;
  size_t         req_size;
  logic          misaligned;
  logic          is_mmio;
  logic          in_range;
  logic [AW-1:0] req_idx;

  assign req        = bus.r_ena_i | bus.w_ena_i;
  assign req_size   = size_t'(bus.sign_mask_i[1:0]);
  assign misaligned = ((req_size == SZ_HALF) && bus.addr_i[0]) ||
                      ((req_size == SZ_WORD) && (bus.addr_i[1:0] != 2'b00));
  assign is_mmio    = (bus.addr_i[31:2] == MMIO_ADDR[31:2]);
  assign in_range   = ({1'b0, bus.addr_i} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, bus.addr_i} < END_ADDR);
  assign req_idx    = AW'((bus.addr_i - BASE_ADDR) >> 2);

  // Captured request
  logic [AW-1:0]     idx_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  size_t             size_q;
  logic              sign_q;
  logic              store_q;

  logic [31:0]       word_buf_q;
  logic [31:0]       r_data_q;
  logic [MMIO_W-1:0] led_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  // NOTE: all clocked state uses <= so every flop samples pre-edge values; = here would
  // create ordering-dependent simulation and mismatch synthesis.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_size == SZ_RSVD || misaligned) state_d = S_ERR;
          else if (is_mmio)                      state_d = S_MMIO;
          else if (in_range)                     state_d = S_FETCH;
          else                                   state_d = S_ERR;
        end
      end
      S_FETCH: state_d = store_q ? S_WRITE : S_READ;
      S_READ, S_WRITE, S_MMIO, S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for stores, both off the fetched word
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    byte_v    = word_buf_q[{lane_q, 3'b000} +: 8];
    half_v    = lane_q[1] ? word_buf_q[31:16] : word_buf_q[15:0];
    load_data = word_buf_q;
    merged    = wdata_q;
    unique case (size_q)
      SZ_BYTE: begin
        load_data = sign_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
        merged    = word_buf_q;
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_data = sign_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        merged    = word_buf_q;
        if (lane_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: begin
        load_data = word_buf_q;
        merged    = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q    <= '0;
      lane_q   <= 2'b00;
      wdata_q  <= 32'h0;
      size_q   <= SZ_BYTE;
      sign_q   <= 1'b0;
      store_q  <= 1'b0;
      r_data_q <= 32'h0;
      led_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state_q == S_ERR);
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            idx_q   <= req_idx;
            lane_q  <= bus.addr_i[1:0];
            wdata_q <= bus.w_data_i;
            size_q  <= req_size;
            sign_q  <= bus.sign_mask_i[2];
            store_q <= bus.w_ena_i;
          end
        end
        S_READ: r_data_q <= load_data;
        S_MMIO: begin
          if (store_q) led_q    <= wdata_q[MMIO_W-1:0];
          else         r_data_q <= 32'(led_q);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array and its read register carry no reset so the memory maps onto block RAM;
  // a reset during FETCH parks the FSM in IDLE, so the WRITE that would commit never happens.
  always_ff @(posedge clk_i) begin
    if (state_q == S_FETCH) word_buf_q <= mem[idx_q];
    if (state_q == S_WRITE) mem[idx_q] <= merged;
  end

  assign bus.r_data_o    = r_data_q;
  assign bus.led_o       = led_q;
  assign bus.err_o       = err_q;
  assign bus.clk_stall_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: word/sub-word access, MMIO, error cases,
// simultaneous enables, back-to-back loads and reset during a store.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 256;  // memory spans 0x1000..0x13FF, clear of MMIO at 0x2000

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.MMIO_W(8)) bus ();

  data_mem_ctrl #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(32'h0000_1000),
    .MMIO_ADDR(32'h0000_2000),
    .MMIO_W   (8),
    .INIT_FILE("")
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Issue one request and follow it until stall drops (bounded to 10 cycles).
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] sm,
                        output int cyc, output logic err_seen, output logic rd_changed);
    logic [31:0] rd0;
    @(negedge clk);
    bus.addr_i      = addr;
    bus.w_data_i    = data;
    bus.sign_mask_i = sm;
    bus.w_ena_i     = wr;
    bus.r_ena_i     = rd;
    rd0             = bus.r_data_o;
    rd_changed      = 1'b0;
    @(posedge clk);
    #1;
    bus.w_ena_i = 1'b0;
    bus.r_ena_i = 1'b0;
    cyc         = 0;
    err_seen    = 1'b0;
    while (bus.clk_stall_o && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.err_o) err_seen = 1'b1;
      if (bus.clk_stall_o && bus.r_data_o !== rd0) rd_changed = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.addr_i = 32'h0; bus.w_data_i = 32'h0; bus.sign_mask_i = 3'b0;
    bus.w_ena_i = 1'b0; bus.r_ena_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.clk_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.clk_stall_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    checks++; if (bus.r_data_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.r_data_o); end
    checks++; if (bus.led_o !== 8'h0) begin errors++; $display("FAIL reset_led: got %h want 0", bus.led_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    int cyc; logic e, c;
    access(1'b1, 1'b0, 32'h1004, 32'hDEADBEEF, 3'b010, cyc, e, c);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL word_store_stall: got %0d want 2", cyc); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_store_err: got %b want 0", e); end
    access(1'b0, 1'b1, 32'h1004, 32'h0, 3'b010, cyc, e, c);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL word_load_stall: got %0d want 2", cyc); end
    checks++; if (bus.r_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load: got %h want deadbeef", bus.r_data_o); end
  endtask

  task automatic test_rmw();
    int cyc; logic e, c;
    access(1'b1, 1'b0, 32'h1005, 32'hFFFF_FF12, 3'b000, cyc, e, c);
    access(1'b1, 1'b0, 32'h1006, 32'hFFFF_8001, 3'b001, cyc, e, c);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL half_store_stall: got %0d want 2", cyc); end
    access(1'b0, 1'b1, 32'h1004, 32'h0, 3'b010, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'h8001_12EF) begin errors++; $display("FAIL rmw_word: got %h want 800112ef", bus.r_data_o); end
    access(1'b0, 1'b1, 32'h1006, 32'h0, 3'b101, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'hFFFF_8001) begin errors++; $display("FAIL half_signed: got %h want ffff8001", bus.r_data_o); end
    access(1'b0, 1'b1, 32'h1007, 32'h0, 3'b000, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'h0000_0080) begin errors++; $display("FAIL byte_unsigned: got %h want 00000080", bus.r_data_o); end
    access(1'b0, 1'b1, 32'h1005, 32'h0, 3'b100, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'h0000_0012) begin errors++; $display("FAIL byte_signed_pos: got %h want 00000012", bus.r_data_o); end
    access(1'b0, 1'b1, 32'h1007, 32'h0, 3'b100, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_signed_neg: got %h want ffffff80", bus.r_data_o); end
    access(1'b0, 1'b1, 32'h1004, 32'h0, 3'b001, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'h0000_12EF) begin errors++; $display("FAIL half_unsigned_lo: got %h want 000012ef", bus.r_data_o); end
    // Last valid word of the memory
    access(1'b1, 1'b0, 32'h13FC, 32'hCAFE_0123, 3'b010, cyc, e, c);
    access(1'b0, 1'b1, 32'h13FC, 32'h0, 3'b010, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'hCAFE_0123 || e !== 1'b0) begin errors++; $display("FAIL last_word: got %h err %b want cafe0123 err 0", bus.r_data_o, e); end
  endtask

  task automatic test_mmio();
    int cyc; logic e, c;
    access(1'b1, 1'b0, 32'h2000, 32'h0000_00A5, 3'b010, cyc, e, c);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL mmio_store_stall: got %0d want 1", cyc); end
    checks++; if (bus.led_o !== 8'hA5) begin errors++; $display("FAIL mmio_led: got %h want a5", bus.led_o); end
    access(1'b0, 1'b1, 32'h2000, 32'h0, 3'b100, cyc, e, c);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL mmio_load_stall: got %0d want 1", cyc); end
    checks++; if (bus.r_data_o !== 32'h0000_00A5) begin errors++; $display("FAIL mmio_load: got %h want 000000a5", bus.r_data_o); end
  endtask

  task automatic test_errors();
    int cyc; logic e, c;
    logic        wr_v [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ad_v [6] = '{32'h1001, 32'h1002, 32'h0FFC, 32'h0FFC, 32'h1400, 32'h1000};
    logic [2:0]  sm_v [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b011};
    access(1'b1, 1'b0, 32'h1000, 32'h1111_1111, 3'b010, cyc, e, c);
    access(1'b0, 1'b1, 32'h2000, 32'h0, 3'b010, cyc, e, c);  // r_data_o = 0xA5
    for (int i = 0; i < 6; i++) begin
      access(wr_v[i], !wr_v[i], ad_v[i], 32'hFFFF_FFFF, sm_v[i], cyc, e, c);
      checks++; if (cyc !== 1 || e !== 1'b1) begin errors++; $display("FAIL err_case%0d: stall %0d err %b want 1 1", i, cyc, e); end
      checks++; if (bus.r_data_o !== 32'h0000_00A5) begin errors++; $display("FAIL err_rdata%0d: got %h want 000000a5", i, bus.r_data_o); end
      @(posedge clk); #1;
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_pulse%0d: got %b want 0", i, bus.err_o); end
    end
    checks++; if (bus.led_o !== 8'hA5) begin errors++; $display("FAIL err_led: got %h want a5", bus.led_o); end
    access(1'b0, 1'b1, 32'h1000, 32'h0, 3'b010, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'h1111_1111) begin errors++; $display("FAIL err_mem1000: got %h want 11111111", bus.r_data_o); end
    access(1'b0, 1'b1, 32'h1004, 32'h0, 3'b010, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'h8001_12EF) begin errors++; $display("FAIL err_mem1004: got %h want 800112ef", bus.r_data_o); end
  endtask

  task automatic test_both_enables();
    int cyc; logic e, c;
    access(1'b1, 1'b1, 32'h1008, 32'h0000_0005, 3'b010, cyc, e, c);
    checks++; if (cyc !== 2 || c !== 1'b0 || bus.r_data_o !== 32'h8001_12EF) begin
      errors++; $display("FAIL both_store: stall %0d rdata_moved %b rdata %h want 2 0 800112ef", cyc, c, bus.r_data_o);
    end
    access(1'b0, 1'b1, 32'h1008, 32'h0, 3'b010, cyc, e, c);
    checks++; if (bus.r_data_o !== 32'h0000_0005) begin errors++; $display("FAIL both_load: got %h want 00000005", bus.r_data_o); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] stall_seq;
    @(negedge clk);
    bus.addr_i = 32'h1004; bus.sign_mask_i = 3'b010; bus.w_ena_i = 1'b0; bus.r_ena_i = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      @(posedge clk); #1;
      stall_seq[i] = bus.clk_stall_o;
    end
    bus.r_ena_i = 1'b0;
    checks++; if (stall_seq !== 6'b110110) begin errors++; $display("FAIL b2b_stall: got %b want 110110", stall_seq); end
    checks++; if (bus.r_data_o !== 32'h8001_12EF) begin errors++; $display("FAIL b2b_rdata: got %h want 800112ef", bus.r_data_o); end
  endtask

  task automatic test_reset_mid_store();
    int cyc; logic e, c;
    access(1'b1, 1'b0, 32'h100C, 32'h0, 3'b010, cyc, e, c);
    @(negedge clk);
    bus.addr_i = 32'h100C; bus.w_data_i = 32'h1; bus.sign_mask_i = 3'b010; bus.w_ena_i = 1'b1;
    @(posedge clk); #1;
    bus.w_ena_i = 1'b0;
    #2 rst_n = 1'b0;   // FSM is in FETCH
    #1;
    checks++; if (bus.clk_stall_o !== 1'b0 || bus.err_o !== 1'b0 || bus.r_data_o !== 32'h0 || bus.led_o !== 8'h0) begin
      errors++; $display("FAIL midreset_outputs: stall %b err %b rdata %h led %h want all 0", bus.clk_stall_o, bus.err_o, bus.r_data_o, bus.led_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 32'h100C, 32'h0, 3'b010, cyc, e, c);
    checks++; if (cyc !== 2 || bus.r_data_o !== 32'h0) begin errors++; $display("FAIL midreset_mem: stall %0d got %h want 2 00000000", cyc, bus.r_data_o); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_rmw();
    test_mmio();
    test_errors();
    test_both_enables();
    test_back_to_back();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
